load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of core and bus.
REQ-002 Parameter: TIMEOUT, 16, max cycles waiting on bus_ready/bus_rvalid before abort; 0 disables.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 rd_en / wr_en  input  1 each  load / store request from datapath; held stable while stall=1.
REQ-006 rd_mask  input  3  access width (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010.
REQ-007 addr  input  ADDR_W  byte address (ALU result).
REQ-008 wdata  input  32  store data (rs2).
REQ-009 rdata  output  32  load result, aligned and extended.
REQ-010 stall  output  1  freezes PC and register-file write while access pending.
REQ-011 bus_req / bus_we  output  1 each  bus request / write qualifier.
REQ-012 bus_addr  output  ADDR_W  word-aligned address (bits [1:0]=0).
REQ-013 bus_be  output  4  byte-lane enables.
REQ-014 bus_wdata  output  32  lane-replicated store data.
REQ-015 bus_ready  input  1  bus accepts request this cycle.
REQ-016 bus_rvalid / bus_rdata  input  1 / 32  read response.
REQ-017 err  output  1  one-cycle pulse: timeout or misaligned abort.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: rd_en|wr_en -> REQ next edge; rd_en and wr_en both high -> store wins.
REQ-020 REQ: bus_req=1, address/be/wdata stable; bus_ready=1 -> WAIT (load) or DONE (store).
REQ-021 WAIT: bus_rvalid=1 -> capture bus_rdata, go DONE; bus_rvalid ignored in every other state.
REQ-022 DONE: lasts exactly one cycle, stall=0, rdata valid; -> IDLE unconditionally.
REQ-023 stall = (rd_en|wr_en) & (state != DONE), combinational; minimum access latency: store 2 cycles, load 3 cycles of stall with zero-wait bus.
REQ-024 bus_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111; bus_we=0 on loads, bus_be still driven.
REQ-025 bus_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-026 rdata: selected lane shifted to bit 0; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-027 Timeout: counter resets on entering REQ/WAIT; reaching TIMEOUT -> DONE, err=1, rdata=0, no retry.
REQ-028 rdata holds last value outside DONE; bus_req=0 outside REQ.

Reset
REQ-029 Asserting reset (even mid-access) forces IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, err=0, counter=0 immediately.
REQ-030 After reset release, a request held high starts a fresh access; any in-flight bus response is ignored.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> IDLE to DONE directly, no bus request, err=1.
REQ-032 Macro undefined: low address bits forced to natural alignment (H clears addr[0], W clears addr[1:0]); misalignment never raises err.

Structure
REQ-033 Package lsu_pkg: state enum, width encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
REQ-034 Sub-module lsu_align: combinational be/wdata steering and load extraction/extension; FSM and counter stay in load_store_unit.

Verification
REQ-035 SW addr 0x100 wdata 0xDEADBEEF, bus_ready immediate -> bus_addr 0x100, be 1111, stall 2 cycles, no err.
REQ-036 LB addr 0x203, bus_rdata 0x80000000, 2 wait cycles -> be 1000, rdata 0xFFFFFF80, stall 5 cycles.
REQ-037 LHU addr 0x202, bus_rdata 0xBEEF1234 -> rdata 0x0000BEEF; SH addr 0x202 wdata 0x0000ABCD -> be 1100, bus_wdata 0xABCDABCD.
REQ-038 LW addr 0x301 with LSU_MISALIGN_TRAP_EN -> no bus_req, err pulse, stall 1 cycle; without macro -> bus_addr 0x300.
REQ-039 Load with bus_ready never asserted, TIMEOUT=16 -> err pulse after 16 cycles, rdata 0, stall released.
REQ-040 Reset asserted during WAIT -> bus_req 0 same cycle; late bus_rvalid ignored; next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and width encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  // Access width encodings (funct3)
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // True when the offset breaks natural alignment for the given width
  function automatic logic lsu_misaligned(input logic [2:0] mask, input logic [1:0] off);
    logic res;
    case (mask)
      LSU_B, LSU_BU: res = 1'b0;
      LSU_H, LSU_HU: res = off[0];
      default:       res = (off != 2'b00);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mask_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane enables, replicated store data and extended load data per width
  always_comb begin
    byte_sel = bus_rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    rdata_o  = bus_rdata_i;
    case (mask_i)
      LSU_B, LSU_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (mask_i == LSU_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      LSU_H, LSU_HU: begin
        // Halfword lane chosen by addr[1] only, so addr[0] is implicitly cleared
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (mask_i == LSU_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/WAIT/DONE bus sequencer with timeout abort.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses abort with err
// instead of being silently aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [2:0]        rd_mask_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              err_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  lsu_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        mask_q;
  logic [1:0]        off_q;
  logic              bus_req_q, bus_we_q, err_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q, rdata_q;

  logic        req, trap, timeout_hit;
  logic [2:0]  al_mask;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign req         = rd_en_i | wr_en_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = lsu_misaligned(rd_mask_i, addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Live request fields steer the lanes in IDLE; latched ones extract load data later
  assign al_mask = (state_q == StIdle) ? rd_mask_i : mask_q;
  assign al_off  = (state_q == StIdle) ? addr_i[1:0] : off_q;

  lsu_align u_align (
    .mask_i      (al_mask),
    .off_i       (al_off),
    .wdata_i     (wdata_i),
    .bus_rdata_i (bus_rdata_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  // Access sequencer with registered bus outputs, result and error pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mask_q      <= '0;
      off_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            mask_q      <= rd_mask_i;
            off_q       <= addr_i[1:0];
            bus_we_q    <= wr_en_i;  // store wins when both are requested
            bus_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_q    <= al_be;
            bus_wdata_q <= al_wdata;
            cnt_q       <= '0;
            if (trap) begin
              state_q <= StDone;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q   <= StReq;
              bus_req_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (bus_ready_i) begin
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= bus_we_q ? StDone : StWait;
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            state_q   <= StDone;
            err_q     <= 1'b1;
            rdata_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWait: begin
          if (bus_rvalid_i) begin
            rdata_q <= al_rdata;
            state_q <= StDone;
          end else if (timeout_hit) begin
            state_q <= StDone;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o     = req & (state_q != StDone);
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule
